// File: rtl/fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response plus the fetch/decode register write port.
interface fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        instWrite;

    modport master (
        input  stall, redirect, redirectPC, imemReady, imemRvalid, imemRdata,
        output imemReq, imemAddr, PC, inst, instWrite
    );

    modport slave (
        output stall, redirect, redirectPC, imemReady, imemRvalid, imemRdata,
        input  imemReq, imemAddr, PC, inst, instWrite
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, stall hold buffer,
// and redirect handling that drops in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic     CLK,
    input  logic     RST,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_out_q;
    logic [31:0] inst_q;
    logic [31:0] hold_q;
    logic        inst_write_q;

    logic [31:0] redirect_tgt;
    logic [31:0] pc_next_seq;
    logic        handshake;

    assign redirect_tgt = bus.redirectPC & ~32'h0000_0003;
    assign pc_next_seq  = pc_q + 32'd4;
    // Request is gated by reset so the bus is quiet while RST is held.
    assign bus.imemReq  = !RST && (state_q == S_REQ) && !bus.stall;
    assign handshake    = bus.imemReq && bus.imemReady;

    assign bus.imemAddr  = pc_q;
    assign bus.PC        = pc_out_q;
    assign bus.inst      = inst_q;
    assign bus.instWrite = inst_write_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pc_out_q     <= 32'h0;
            inst_q       <= NOP_INST;
            hold_q       <= 32'h0;
            inst_write_q <= 1'b0;
        end else begin
            inst_write_q <= 1'b0;
            case (state_q)
                S_REQ: begin
                    if (bus.redirect) begin
                        pc_q <= redirect_tgt;
                        if (handshake) begin
                            state_q <= S_KILL;
                        end
                    end else if (handshake) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect) begin
                        pc_q    <= redirect_tgt;
                        state_q <= bus.imemRvalid ? S_REQ : S_KILL;
                    end else if (bus.imemRvalid) begin
                        if (bus.stall) begin
                            hold_q  <= bus.imemRdata;
                            state_q <= S_HOLD;
                        end else begin
                            pc_out_q     <= pc_q;
                            inst_q       <= bus.imemRdata;
                            inst_write_q <= 1'b1;
                            pc_q         <= pc_next_seq;
                            state_q      <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.redirect) begin
                        pc_q    <= redirect_tgt;
                        state_q <= S_REQ;
                    end else if (!bus.stall) begin
                        pc_out_q     <= pc_q;
                        inst_q       <= hold_q;
                        inst_write_q <= 1'b1;
                        pc_q         <= pc_next_seq;
                        state_q      <= S_REQ;
                    end
                end
                S_KILL: begin
                    // Stay until the orphaned response drains; a redirect only retargets.
                    if (bus.redirect) begin
                        pc_q <= redirect_tgt;
                    end
                    if (bus.imemRvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC/inst pairs queued with stimulus, popped on instWrite.
module tb_fetch_unit;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic CLK;
    logic RST;

    fetch_if bus ();
    fetch_if wif ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .NOP_INST(NOP)) u_wrap (
        .CLK (CLK),
        .RST (RST),
        .bus (wif)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_del = 0;
    int   cyc = 0;
    int   last_wr = -100;
    int   gap = 0;
    int   lat = 1;
    bit   wrap_seen = 0;

    int          mem_cnt;
    logic        mem_busy;
    logic [31:0] mem_addr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h00A0_0093;
        return a ^ 32'h1357_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory with programmable latency; reset together with the DUT.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_busy       <= 1'b0;
            mem_cnt        <= 0;
            mem_addr       <= 32'h0;
            bus.imemRvalid <= 1'b0;
            bus.imemRdata  <= 32'h0;
        end else begin
            bus.imemRvalid <= 1'b0;
            if (bus.imemReq && bus.imemReady) begin
                if (lat <= 1) begin
                    bus.imemRvalid <= 1'b1;
                    bus.imemRdata  <= mem_word(bus.imemAddr);
                end else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= lat - 1;
                    mem_addr <= bus.imemAddr;
                end
            end else if (mem_busy) begin
                if (mem_cnt == 1) begin
                    bus.imemRvalid <= 1'b1;
                    bus.imemRdata  <= mem_word(mem_addr);
                    mem_busy       <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    // Free-running 1-cycle memory for the wrap instance.
    assign wif.stall      = 1'b0;
    assign wif.redirect   = 1'b0;
    assign wif.redirectPC = 32'h0;
    assign wif.imemReady  = 1'b1;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            wif.imemRvalid <= 1'b0;
            wif.imemRdata  <= 32'h0;
        end else begin
            wif.imemRvalid <= wif.imemReq && wif.imemReady;
            wif.imemRdata  <= mem_word(wif.imemAddr);
        end
    end

    task automatic tick();
        exp_t e;
        @(negedge CLK);
        cyc++;
        if (!RST && bus.instWrite) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 32'(bus.instWrite), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("deliver_pc", bus.PC, e.pc);
                check_eq("deliver_inst", bus.inst, e.inst);
            end
            gap     = cyc - last_wr;
            last_wr = cyc;
            n_del++;
        end
        if (!RST && wif.instWrite && !wrap_seen) begin
            check_eq("wrap_pc", wif.PC, WRAP_PC);
            check_eq("wrap_inst", wif.inst, mem_word(WRAP_PC));
            check_eq("wrap_next_addr", wif.imemAddr, 32'h0);
            wrap_seen = 1;
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = mem_word(a);
        sb.push_back(e);
    endtask

    task automatic wait_del(input int target, input int budget);
        int k = 0;
        while (n_del < target && k < budget) begin
            tick();
            k++;
        end
        if (n_del < target) check_eq("delivery_timeout", 32'(n_del), 32'(target));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        sb.delete();
        n_del   = 0;
        last_wr = -100;
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        RST = 1'b0;
    endtask

    initial begin
        RST            = 1'b1;
        bus.stall      = 1'b0;
        bus.redirect   = 1'b0;
        bus.redirectPC = 32'h0;
        bus.imemReady  = 1'b1;

        // Reset values
        tick();
        tick();
        check_eq("rst_pc", bus.PC, 32'h0);
        check_eq("rst_inst", bus.inst, NOP);
        check_eq("rst_instwrite", 32'(bus.instWrite), 32'd0);
        check_eq("rst_req", 32'(bus.imemReq), 32'd0);
        check_eq("rst_addr", bus.imemAddr, 32'h0);
        check_eq("rst_wrap_addr", wif.imemAddr, WRAP_PC);

        // Sequential fetch, one instruction every 2 cycles
        lat = 1;
        do_reset();
        #1;
        check_eq("first_req", 32'(bus.imemReq), 32'd1);
        check_eq("first_addr", bus.imemAddr, 32'h0);
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        wait_del(1, 10);
        wait_del(2, 10);
        check_eq("seq_gap1", 32'(gap), 32'd2);
        wait_del(3, 10);
        check_eq("seq_gap2", 32'(gap), 32'd2);
        bus.stall = 1'b1;
        tick();
        check_eq("seq_sb_empty", 32'(sb.size()), 32'd0);

        // Stall while the response returns
        do_reset();
        push_exp(32'h0);
        push_exp(32'h4);
        wait_del(1, 10);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_nowrite", 32'(bus.instWrite), 32'd0);
            check_eq("stall_noreq", 32'(bus.imemReq), 32'd0);
        end
        bus.stall = 1'b0;
        wait_del(2, 5);
        check_eq("stall_next_addr", bus.imemAddr, 32'h8);
        bus.stall = 1'b1;
        tick();
        check_eq("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect while waiting drops the late word
        lat = 3;
        do_reset();
        tick();
        bus.redirect   = 1'b1;
        bus.redirectPC = 32'h0000_0103;
        tick();
        bus.redirect = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("redir_nowrite", 32'(bus.instWrite), 32'd0);
            if (bus.imemReq) break;
            tick();
        end
        check_eq("redir_req", 32'(bus.imemReq), 32'd1);
        check_eq("redir_addr", bus.imemAddr, 32'h0000_0100);
        lat = 1;
        push_exp(32'h0000_0100);
        wait_del(1, 10);
        bus.stall = 1'b1;
        tick();
        check_eq("redir_sb_empty", 32'(sb.size()), 32'd0);

        // Memory backpressure
        bus.imemReady = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_req", 32'(bus.imemReq), 32'd1);
            check_eq("bp_addr", bus.imemAddr, 32'h0);
        end
        bus.imemReady = 1'b1;
        push_exp(32'h0);
        wait_del(1, 10);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("bp_count", 32'(n_del), 32'd1);
        check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of S_WAIT
        do_reset();
        push_exp(32'h0);
        push_exp(32'h4);
        wait_del(2, 12);
        lat = 3;
        tick();
        #2;
        RST = 1'b1;
        #1;
        check_eq("arst_pc", bus.PC, 32'h0);
        check_eq("arst_inst", bus.inst, NOP);
        check_eq("arst_instwrite", 32'(bus.instWrite), 32'd0);
        check_eq("arst_req", 32'(bus.imemReq), 32'd0);
        check_eq("arst_addr", bus.imemAddr, 32'h0);
        lat = 1;
        do_reset();
        push_exp(32'h0);
        wait_del(1, 10);
        bus.stall = 1'b1;
        tick();
        check_eq("arst_sb_empty", 32'(sb.size()), 32'd0);

        check_eq("wrap_seen", 32'(wrap_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
